// File: rtl/div_pkg.sv
// Shared types and constants for the repeated-subtraction divider.
package div_pkg;

    localparam int unsigned DefaultWidth = 16;

    typedef enum logic [2:0] {
        StIdle,
        StLda,
        StLdb,
        StChk,
        StSub,
        StDone
    } state_e;

endpackage

// File: rtl/div_datapath.sv
// Divider datapath: remainder, divisor and quotient registers with the
// subtractor, the R >= D comparator and the zero-divisor detector.
module div_datapath
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ld_r,
    input  logic             ld_d,
    input  logic             clr_q,
    input  logic             set_q,
    input  logic             dec_r,
    input  logic             inc_q,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             ge,
    output logic             dz
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] q_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
            d_q <= '0;
            q_q <= '0;
        end else begin
            if (ld_r) begin
                r_q <= data_in;
            end else if (dec_r) begin
                r_q <= r_q - d_q;
            end

            if (ld_d) begin
                d_q <= data_in;
            end

            if (clr_q) begin
                q_q <= '0;
            end else if (set_q) begin
                q_q <= '1;
            end else if (inc_q) begin
                q_q <= q_q + WIDTH'(1);
            end
        end
    end

    assign ge        = (r_q >= d_q);
    assign dz        = (d_q == '0);
    assign quotient  = q_q;
    assign remainder = r_q;

endmodule

// File: rtl/div_repeated_sub.sv
// Sequential unsigned divider: controller FSM sequencing serial operand
// loads and repeated subtraction on div_datapath.
module div_repeated_sub
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done,
    output logic             busy,
    output logic             dz_err
);

    state_e state_q;
    logic   busy_q;
    logic   done_q;
    logic   dz_err_q;

    logic ld_r;
    logic ld_d;
    logic clr_q;
    logic set_q;
    logic sub_step;
    logic ge;
    logic dz;

    // Datapath enables act on the edge that leaves the current state.
    always_comb begin
        ld_r     = (state_q == StLda);
        clr_q    = (state_q == StLda);
        ld_d     = (state_q == StLdb);
        set_q    = (state_q == StChk) && dz;
        sub_step = (state_q == StSub) && ge;
    end

    div_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .ld_r     (ld_r),
        .ld_d     (ld_d),
        .clr_q    (clr_q),
        .set_q    (set_q),
        .dec_r    (sub_step),
        .inc_q    (sub_step),
        .quotient (quotient),
        .remainder(remainder),
        .ge       (ge),
        .dz       (dz)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_err_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StLda;
                        busy_q  <= 1'b1;
                    end
                end
                StLda: begin
                    state_q  <= StLdb;
                    dz_err_q <= 1'b0;
                end
                StLdb: begin
                    state_q <= StChk;
                end
                StChk: begin
                    if (dz) begin
                        state_q  <= StDone;
                        dz_err_q <= 1'b1;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end else begin
                        state_q <= StSub;
                    end
                end
                StSub: begin
                    if (!ge) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    // A held start must not retrigger; wait for it to drop.
                    if (!start) begin
                        state_q <= StIdle;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign dz_err = dz_err_q;

endmodule

// File: tb/tb_div_repeated_sub.sv
// Self-checking bench for div_repeated_sub: vector table with a result
// scoreboard, plus hand sequences for reset-in-flight and held start.
module tb_div_repeated_sub;

    localparam int W     = 16;
    localparam int Bound = 400;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } vec_t;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] data_in = '0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         done;
    logic         busy;
    logic         dz_err;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[9];
    vec_t sb[$];

    div_repeated_sub #(
        .WIDTH(W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .data_in  (data_in),
        .quotient (quotient),
        .remainder(remainder),
        .done     (done),
        .busy     (busy),
        .dz_err   (dz_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives E0 (start), E1 (dividend) and E2 (divisor).
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        @(negedge clk) begin
            start   = 1'b0;
            data_in = a;
        end
        @(posedge clk);
        #1;
        chk("busy_e1", busy, 1);
        chk("dz_clr_e1", dz_err, 0);
        @(negedge clk) data_in = b;
        @(posedge clk);
    endtask

    task automatic finish_op(input bit hold);
        vec_t e;
        int   k;
        bit   got;
        k   = 2;
        got = 1'b0;
        e   = sb.pop_front();
        while (!got && k < Bound) begin
            @(posedge clk);
            k++;
            #1;
            if (done) got = 1'b1;
        end
        chk("done_seen", got, 1);
        chk("latency", k, e.dz ? 3 : 4 + int'(e.q));
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("dz_err", dz_err, e.dz);
        chk("busy_at_done", busy, 0);
        if (hold) begin
            @(negedge clk) start = 1'b1;
            repeat (5) @(posedge clk);
            #1;
            chk("hold_done", done, 1);
            chk("hold_busy", busy, 0);
            chk("hold_quot", quotient, e.q);
        end
        @(negedge clk) start = 1'b0;
        @(posedge clk);
        #1;
        chk("done_drop", done, 0);
        chk("idle_quot", quotient, e.q);
        chk("idle_rem", remainder, e.r);
    endtask

    initial begin
        vecs[0] = '{a: 16'd17,    b: 16'd5,     q: 16'd3,    r: 16'd2,   dz: 1'b0};
        vecs[1] = '{a: 16'd100,   b: 16'd0,     q: 16'hFFFF, r: 16'd100, dz: 1'b1};
        vecs[2] = '{a: 16'd3,     b: 16'd7,     q: 16'd0,    r: 16'd3,   dz: 1'b0};
        vecs[3] = '{a: 16'd0,     b: 16'd9,     q: 16'd0,    r: 16'd0,   dz: 1'b0};
        vecs[4] = '{a: 16'hFFFF,  b: 16'hFFFF,  q: 16'd1,    r: 16'd0,   dz: 1'b0};
        vecs[5] = '{a: 16'd40,    b: 16'd1,     q: 16'd40,   r: 16'd0,   dz: 1'b0};
        vecs[6] = '{a: 16'd1000,  b: 16'd7,     q: 16'd142,  r: 16'd6,   dz: 1'b0};
        vecs[7] = '{a: 16'hFFFF,  b: 16'd256,   q: 16'd255,  r: 16'd255, dz: 1'b0};
        vecs[8] = '{a: 16'd0,     b: 16'd0,     q: 16'hFFFF, r: 16'd0,   dz: 1'b1};

        #1 rst_n = 1'b0;
        #10;
        chk("rst_quot", quotient, 0);
        chk("rst_rem", remainder, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dz", dz_err, 0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            sb.push_back(vecs[i]);
            launch(vecs[i].a, vecs[i].b);
            finish_op(1'b0);
        end

        // Reset asserted while in SUB of 17/5.
        launch(16'd17, 16'd5);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("mid_quot", quotient, 1);
        chk("mid_rem", remainder, 12);
        chk("mid_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_quot", quotient, 0);
        chk("async_rem", remainder, 0);
        chk("async_busy", busy, 0);
        chk("async_done", done, 0);
        chk("async_dz", dz_err, 0);
        @(negedge clk) rst_n = 1'b1;
        sb.push_back('{a: 16'd20, b: 16'd4, q: 16'd5, r: 16'd0, dz: 1'b0});
        launch(16'd20, 16'd4);
        finish_op(1'b0);

        // Held start through DONE, then a fresh operation after a zero divide.
        sb.push_back('{a: 16'd100, b: 16'd0, q: 16'hFFFF, r: 16'd100, dz: 1'b1});
        launch(16'd100, 16'd0);
        finish_op(1'b1);
        chk("idle_dz_held", dz_err, 1);
        sb.push_back('{a: 16'd5, b: 16'd3, q: 16'd1, r: 16'd2, dz: 1'b0});
        launch(16'd5, 16'd3);
        finish_op(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
